// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control FSM (Moore).
// Sequences fetch/decode/execute/memory/write-back for R-type, addi/addiu,
// lw/sw, beq/bne, j and, optionally, mult/div with a timeout, plus precise
// exceptions that save EPC and vector the PC.
// Optional feature macro: CTRL_MULDIV_EN (mult/div decode, handshake, timeout).
module mc_control_fsm #(
  parameter int unsigned MEM_WAIT       = 2,
  parameter int unsigned MULDIV_TIMEOUT = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [5:0] OPCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       MulDivDone,
  input  logic       DivZero,
  output logic [4:0] Estado,
  output logic       PCWrite,
  output logic [1:0] IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic [1:0] ALUSrcA,
  output logic [2:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic       RegWrite,
  output logic [2:0] RegDst,
  output logic [2:0] MemToReg,
  output logic [2:0] PCSrc,
  output logic       EPCWrite,
  output logic [1:0] ExcCode,
  output logic       MulDivStart,
  output logic       MulDivSel,
  output logic       HiLoWrite,
  output logic       DpReset
);

  localparam logic [4:0] S_RESET   = 5'd0;
  localparam logic [4:0] S_FETCH   = 5'd1;
  localparam logic [4:0] S_FWAIT   = 5'd2;
  localparam logic [4:0] S_DECODE  = 5'd3;
  localparam logic [4:0] S_REXEC   = 5'd4;
  localparam logic [4:0] S_RWB     = 5'd5;
  localparam logic [4:0] S_IEXEC   = 5'd6;
  localparam logic [4:0] S_IWB     = 5'd7;
  localparam logic [4:0] S_ADDR    = 5'd8;
  localparam logic [4:0] S_MWAIT   = 5'd9;
  localparam logic [4:0] S_LWB     = 5'd10;
  localparam logic [4:0] S_STORE   = 5'd11;
  localparam logic [4:0] S_BRANCH  = 5'd12;
  localparam logic [4:0] S_JUMP    = 5'd13;
  localparam logic [4:0] S_EXC     = 5'd17;
  localparam logic [4:0] S_EXCJ    = 5'd18;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] EXC_OPC = 2'b00;
  localparam logic [1:0] EXC_OVF = 2'b01;

  localparam logic [CNT_W-1:0] MW_LAST = CNT_W'(MEM_WAIT - 1);

`ifdef CTRL_MULDIV_EN
  localparam logic [4:0] S_MDSTART = 5'd14;
  localparam logic [4:0] S_MDRUN   = 5'd15;
  localparam logic [4:0] S_MDWB    = 5'd16;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [1:0] EXC_DIV0  = 2'b10;
  localparam logic [1:0] EXC_TOUT  = 2'b11;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MULDIV_TIMEOUT - 1);
`else
  localparam logic [31:0] TO_BITS = 32'(MULDIV_TIMEOUT);
  logic unused_muldiv;
  assign unused_muldiv = ^{MulDivDone, DivZero, TO_BITS};
`endif

  logic [4:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       exc_q, exc_d;

  logic       pc_write, mem_write, ir_write, mdr_write, ab_write, aluout_write;
  logic       reg_write, epc_write, md_start, md_sel, hilo_write, dp_reset;
  logic [1:0] iord, alu_src_a, exc_code;
  logic [2:0] alu_src_b, alu_ctrl, reg_dst, mem_to_reg, pc_src;

  // State, shared wait/timeout counter and pending exception code.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
  end

  // Next-state, counter and exception-code selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = '0;
        state_d = S_FWAIT;
      end
      S_FWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MW_LAST) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXC;
        case (OPCode)
          OP_RTYPE: begin
            case (Funct)
              FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = S_REXEC;
`ifdef CTRL_MULDIV_EN
              FN_MULT, FN_DIV:                state_d = S_MDSTART;
`endif
              default: ;
            endcase
          end
          OP_ADDI, OP_ADDIU: state_d = S_IEXEC;
          OP_LW, OP_SW:      state_d = S_ADDR;
          OP_BEQ, OP_BNE:    state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          default: ;
        endcase
        if (state_d == S_EXC) exc_d = EXC_OPC;
      end
      S_REXEC: begin
        if (((Funct == FN_ADD) || (Funct == FN_SUB)) && Overflow) begin
          exc_d   = EXC_OVF;
          state_d = S_EXC;
        end else begin
          state_d = S_RWB;
        end
      end
      S_RWB: state_d = S_FETCH;
      S_IEXEC: begin
        if ((OPCode == OP_ADDI) && Overflow) begin
          exc_d   = EXC_OVF;
          state_d = S_EXC;
        end else begin
          state_d = S_IWB;
        end
      end
      S_IWB: state_d = S_FETCH;
      S_ADDR: begin
        cnt_d   = '0;
        state_d = (OPCode == OP_LW) ? S_MWAIT : S_STORE;
      end
      S_MWAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MW_LAST) state_d = S_LWB;
      end
      S_LWB: state_d = S_FETCH;
      S_STORE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MW_LAST) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef CTRL_MULDIV_EN
      S_MDSTART: begin
        cnt_d = '0;
        if ((Funct == FN_DIV) && DivZero) begin
          exc_d   = EXC_DIV0;
          state_d = S_EXC;
        end else begin
          state_d = S_MDRUN;
        end
      end
      // Done is tested before the timeout so a result arriving on the last
      // allowed cycle is still accepted.
      S_MDRUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (MulDivDone) begin
          state_d = S_MDWB;
        end else if (cnt_q == TO_LAST) begin
          exc_d   = EXC_TOUT;
          state_d = S_EXC;
        end
      end
      S_MDWB: state_d = S_FETCH;
`endif
      S_EXC:  state_d = S_EXCJ;
      S_EXCJ: state_d = S_FETCH;
      default: state_d = S_RESET;
    endcase
  end

  // Datapath control decode from the current state.
  always_comb begin
    pc_write     = 1'b0;
    iord         = 2'b00;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    ab_write     = 1'b0;
    aluout_write = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 3'b000;
    alu_ctrl     = 3'b000;
    reg_write    = 1'b0;
    reg_dst      = 3'b000;
    mem_to_reg   = 3'b000;
    pc_src       = 3'b000;
    epc_write    = 1'b0;
    exc_code     = 2'b00;
    md_start     = 1'b0;
    md_sel       = 1'b0;
    hilo_write   = 1'b0;
    dp_reset     = 1'b0;
    case (state_q)
      S_RESET: begin
        dp_reset   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 3'b100;
        mem_to_reg = 3'b111;
      end
      S_FETCH: begin
        alu_src_b = 3'b001;
        alu_ctrl  = 3'b001;
        pc_write  = 1'b1;
      end
      S_FWAIT: ir_write = (cnt_q == MW_LAST);
      S_DECODE: begin
        ab_write     = 1'b1;
        aluout_write = 1'b1;
        alu_src_b    = 3'b011;
        alu_ctrl     = 3'b001;
      end
      S_REXEC: begin
        alu_src_a    = 2'b01;
        aluout_write = 1'b1;
        case (Funct)
          FN_SUB:  alu_ctrl = 3'b010;
          FN_AND:  alu_ctrl = 3'b011;
          FN_SLT:  alu_ctrl = 3'b111;
          default: alu_ctrl = 3'b001;
        endcase
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 3'b001;
      end
      S_IEXEC: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 3'b010;
        alu_ctrl     = 3'b001;
        aluout_write = 1'b1;
      end
      S_IWB: reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 3'b010;
        alu_ctrl     = 3'b001;
        aluout_write = 1'b1;
      end
      S_MWAIT: begin
        iord      = 2'b01;
        mdr_write = (cnt_q == MW_LAST);
      end
      S_LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 3'b001;
      end
      S_STORE: begin
        iord      = 2'b01;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_ctrl  = 3'b010;
        pc_src    = 3'b001;
        pc_write  = ((OPCode == OP_BEQ) && Zero) || ((OPCode == OP_BNE) && !Zero);
      end
      S_JUMP: begin
        pc_src   = 3'b010;
        pc_write = 1'b1;
      end
`ifdef CTRL_MULDIV_EN
      S_MDSTART: begin
        md_start = 1'b1;
        md_sel   = (Funct == FN_DIV);
      end
      S_MDWB: hilo_write = 1'b1;
`endif
      S_EXC: begin
        alu_src_b = 3'b001;
        alu_ctrl  = 3'b010;
        epc_write = 1'b1;
        exc_code  = exc_q;
      end
      S_EXCJ: begin
        pc_src   = 3'b011;
        pc_write = 1'b1;
        exc_code = exc_q;
      end
      default: ;
    endcase
  end

  // RESET drives its own strobes once released; while Reset_n is low every
  // control output is forced quiet so nothing in the datapath is written.
  assign Estado      = state_q;
  assign PCWrite     = Reset_n & pc_write;
  assign IorD        = Reset_n ? iord : '0;
  assign MemWrite    = Reset_n & mem_write;
  assign IRWrite     = Reset_n & ir_write;
  assign MDRWrite    = Reset_n & mdr_write;
  assign ABWrite     = Reset_n & ab_write;
  assign ALUOutWrite = Reset_n & aluout_write;
  assign ALUSrcA     = Reset_n ? alu_src_a : '0;
  assign ALUSrcB     = Reset_n ? alu_src_b : '0;
  assign ALUCtrl     = Reset_n ? alu_ctrl : '0;
  assign RegWrite    = Reset_n & reg_write;
  assign RegDst      = Reset_n ? reg_dst : '0;
  assign MemToReg    = Reset_n ? mem_to_reg : '0;
  assign PCSrc       = Reset_n ? pc_src : '0;
  assign EPCWrite    = Reset_n & epc_write;
  assign ExcCode     = Reset_n ? exc_code : '0;
  assign MulDivStart = Reset_n & md_start;
  assign MulDivSel   = Reset_n & md_sel;
  assign HiLoWrite   = Reset_n & hilo_write;
  assign DpReset     = Reset_n & dp_reset;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: instance 0 uses MEM_WAIT=2, instance 1
// uses MEM_WAIT=3. Cycle 1 of each instruction is its FETCH cycle.
module tb_mc_control_fsm;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [5:0] OPCode = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       Overflow = 1'b0;
  logic       MulDivDone = 1'b0;
  logic       DivZero = 1'b0;

  logic [4:0] Estado [2];
  logic       PCWrite [2];
  logic [1:0] IorD [2];
  logic       MemWrite [2];
  logic       IRWrite [2];
  logic       MDRWrite [2];
  logic       ABWrite [2];
  logic       ALUOutWrite [2];
  logic [1:0] ALUSrcA [2];
  logic [2:0] ALUSrcB [2];
  logic [2:0] ALUCtrl [2];
  logic       RegWrite [2];
  logic [2:0] RegDst [2];
  logic [2:0] MemToReg [2];
  logic [2:0] PCSrc [2];
  logic       EPCWrite [2];
  logic [1:0] ExcCode [2];
  logic       MulDivStart [2];
  logic       MulDivSel [2];
  logic       HiLoWrite [2];
  logic       DpReset [2];
  logic       anyout [2];

  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_control_fsm #(.MEM_WAIT(2 + g), .MULDIV_TIMEOUT(64), .CNT_W(7)) u_dut (
      .Clock(Clock), .Reset_n(Reset_n), .OPCode(OPCode), .Funct(Funct),
      .Zero(Zero), .Overflow(Overflow), .MulDivDone(MulDivDone), .DivZero(DivZero),
      .Estado(Estado[g]), .PCWrite(PCWrite[g]), .IorD(IorD[g]), .MemWrite(MemWrite[g]),
      .IRWrite(IRWrite[g]), .MDRWrite(MDRWrite[g]), .ABWrite(ABWrite[g]),
      .ALUOutWrite(ALUOutWrite[g]), .ALUSrcA(ALUSrcA[g]), .ALUSrcB(ALUSrcB[g]),
      .ALUCtrl(ALUCtrl[g]), .RegWrite(RegWrite[g]), .RegDst(RegDst[g]),
      .MemToReg(MemToReg[g]), .PCSrc(PCSrc[g]), .EPCWrite(EPCWrite[g]),
      .ExcCode(ExcCode[g]), .MulDivStart(MulDivStart[g]), .MulDivSel(MulDivSel[g]),
      .HiLoWrite(HiLoWrite[g]), .DpReset(DpReset[g])
    );
    assign anyout[g] = |{PCWrite[g], IorD[g], MemWrite[g], IRWrite[g], MDRWrite[g],
                         ABWrite[g], ALUOutWrite[g], ALUSrcA[g], ALUSrcB[g], ALUCtrl[g],
                         RegWrite[g], RegDst[g], MemToReg[g], PCSrc[g], EPCWrite[g],
                         ExcCode[g], MulDivStart[g], MulDivSel[g], HiLoWrite[g], DpReset[g]};
  end

  // Reset both instances, load the instruction fields and stop at cycle 1 (FETCH).
  task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
    OPCode = op; Funct = fn; Zero = 1'b0; Overflow = 1'b0;
    MulDivDone = 1'b0; DivZero = 1'b0;
    @(negedge Clock); Reset_n = 1'b0;
    @(negedge Clock); @(negedge Clock); Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_reset;
    start_instr(6'h23, 6'h00);
    @(negedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    total++; if (Estado[0] !== 5'd0 || Estado[1] !== 5'd0) $display("FAIL reset_async_state got %0d/%0d exp 0", Estado[0], Estado[1]); else passed++;
    total++; if (anyout[0] !== 1'b0 || anyout[1] !== 1'b0) $display("FAIL reset_outputs_zero got %b/%b exp 0", anyout[0], anyout[1]); else passed++;
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    total++; if (Estado[0] !== 5'd0) $display("FAIL reset_first_state got %0d exp 0", Estado[0]); else passed++;
    total++; if ({RegWrite[0], RegDst[0], MemToReg[0], DpReset[0]} !== {1'b1, 3'b100, 3'b111, 1'b1})
      $display("FAIL reset_sp_init got RegWrite=%b RegDst=%b MemToReg=%b DpReset=%b exp 1 100 111 1", RegWrite[0], RegDst[0], MemToReg[0], DpReset[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd1 || PCWrite[0] !== 1'b1 || ALUSrcB[0] !== 3'b001 || ALUCtrl[0] !== 3'b001)
      $display("FAIL reset_then_fetch got st=%0d PCWrite=%b ALUSrcB=%b ALUCtrl=%b exp 1 1 001 001", Estado[0], PCWrite[0], ALUSrcB[0], ALUCtrl[0]); else passed++;
  endtask

  task automatic test_rtype;
    start_instr(6'h00, 6'h20);
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd2 || IRWrite[0] !== 1'b0) $display("FAIL add_c2 got st=%0d IRWrite=%b exp 2 0", Estado[0], IRWrite[0]); else passed++;
    @(negedge Clock);
    total++; if (IRWrite[0] !== 1'b1) $display("FAIL add_irwrite_c3 got %b exp 1", IRWrite[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd3 || ABWrite[0] !== 1'b1 || ALUSrcB[0] !== 3'b011) $display("FAIL add_decode got st=%0d AB=%b SrcB=%b exp 3 1 011", Estado[0], ABWrite[0], ALUSrcB[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd4 || ALUSrcA[0] !== 2'b01 || ALUSrcB[0] !== 3'b000 || ALUCtrl[0] !== 3'b001 || ALUOutWrite[0] !== 1'b1)
      $display("FAIL add_exec got st=%0d SrcA=%b SrcB=%b Ctrl=%b exp 4 01 000 001", Estado[0], ALUSrcA[0], ALUSrcB[0], ALUCtrl[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd5 || RegWrite[0] !== 1'b1 || RegDst[0] !== 3'b001) $display("FAIL add_wb_c6 got st=%0d RegWrite=%b RegDst=%b exp 5 1 001", Estado[0], RegWrite[0], RegDst[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd1) $display("FAIL add_back_to_fetch got %0d exp 1", Estado[0]); else passed++;
    // slt ignores Overflow
    start_instr(6'h00, 6'h2A);
    Overflow = 1'b1;
    repeat (4) @(negedge Clock);
    total++; if (ALUCtrl[0] !== 3'b111) $display("FAIL slt_aluctrl got %b exp 111", ALUCtrl[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd5) $display("FAIL slt_no_ovf_exc got %0d exp 5", Estado[0]); else passed++;
  endtask

  task automatic test_overflow;
    start_instr(6'h00, 6'h22);
    Overflow = 1'b1;
    repeat (4) @(negedge Clock);
    total++; if (ALUCtrl[0] !== 3'b010) $display("FAIL sub_aluctrl got %b exp 010", ALUCtrl[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd17 || EPCWrite[0] !== 1'b1 || ExcCode[0] !== 2'b01 || ALUCtrl[0] !== 3'b010 || ALUSrcB[0] !== 3'b001)
      $display("FAIL ovf_exc got st=%0d EPC=%b code=%b Ctrl=%b SrcB=%b exp 17 1 01 010 001", Estado[0], EPCWrite[0], ExcCode[0], ALUCtrl[0], ALUSrcB[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd18 || PCSrc[0] !== 3'b011 || PCWrite[0] !== 1'b1 || ExcCode[0] !== 2'b01)
      $display("FAIL ovf_exc_jump got st=%0d PCSrc=%b PCWrite=%b code=%b exp 18 011 1 01", Estado[0], PCSrc[0], PCWrite[0], ExcCode[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd1 || ExcCode[0] !== 2'b00) $display("FAIL ovf_return got st=%0d code=%b exp 1 00", Estado[0], ExcCode[0]); else passed++;
    // addi traps, addiu does not
    start_instr(6'h08, 6'h00);
    Overflow = 1'b1;
    repeat (4) @(negedge Clock);
    total++; if (Estado[0] !== 5'd6 || ALUSrcB[0] !== 3'b010) $display("FAIL addi_exec got st=%0d SrcB=%b exp 6 010", Estado[0], ALUSrcB[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd17 || ExcCode[0] !== 2'b01) $display("FAIL addi_ovf got st=%0d code=%b exp 17 01", Estado[0], ExcCode[0]); else passed++;
    start_instr(6'h09, 6'h00);
    Overflow = 1'b1;
    repeat (5) @(negedge Clock);
    total++; if (Estado[0] !== 5'd7 || RegWrite[0] !== 1'b1 || RegDst[0] !== 3'b000) $display("FAIL addiu_wb got st=%0d RegWrite=%b RegDst=%b exp 7 1 000", Estado[0], RegWrite[0], RegDst[0]); else passed++;
  endtask

  task automatic test_branch;
    logic [5:0] ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       tk  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_instr(ops[i], 6'h00);
      Zero = zs[i];
      repeat (4) @(negedge Clock);
      total++; if (Estado[0] !== 5'd12 || PCWrite[0] !== tk[i]) $display("FAIL branch%0d got st=%0d PCWrite=%b exp 12 %b", i, Estado[0], PCWrite[0], tk[i]); else passed++;
      if (tk[i]) begin
        total++; if (PCSrc[0] !== 3'b001) $display("FAIL branch%0d_pcsrc got %b exp 001", i, PCSrc[0]); else passed++;
      end
      @(negedge Clock);
      total++; if (Estado[0] !== 5'd1) $display("FAIL branch%0d_latency got %0d exp 1", i, Estado[0]); else passed++;
    end
    start_instr(6'h02, 6'h00);
    repeat (4) @(negedge Clock);
    total++; if (Estado[0] !== 5'd13 || PCSrc[0] !== 3'b010 || PCWrite[0] !== 1'b1) $display("FAIL jump got st=%0d PCSrc=%b PCWrite=%b exp 13 010 1", Estado[0], PCSrc[0], PCWrite[0]); else passed++;
  endtask

  task automatic test_load_store;
    // lw on the MEM_WAIT=3 instance: F_WAIT c2..c4, DECODE c5, ADDR c6, M_WAIT c7..c9, L_WB c10
    start_instr(6'h23, 6'h00);
    for (int c = 2; c <= 11; c++) begin
      @(negedge Clock);
      total++; if (MDRWrite[1] !== (c == 9)) $display("FAIL lw_mdrwrite_c%0d got %b exp %b", c, MDRWrite[1], (c == 9)); else passed++;
      if (c == 4) begin
        total++; if (IRWrite[1] !== 1'b1) $display("FAIL lw_irwrite_c4 got %b exp 1", IRWrite[1]); else passed++;
      end
      if (c == 6) begin
        total++; if (Estado[1] !== 5'd8 || ALUOutWrite[1] !== 1'b1) $display("FAIL lw_addr got st=%0d ALUOutWrite=%b exp 8 1", Estado[1], ALUOutWrite[1]); else passed++;
      end
      if (c >= 7 && c <= 9) begin
        total++; if (Estado[1] !== 5'd9 || IorD[1] !== 2'b01) $display("FAIL lw_mwait_c%0d got st=%0d IorD=%b exp 9 01", c, Estado[1], IorD[1]); else passed++;
      end
      if (c == 10) begin
        total++; if (Estado[1] !== 5'd10 || RegWrite[1] !== 1'b1 || MemToReg[1] !== 3'b001 || RegDst[1] !== 3'b000)
          $display("FAIL lw_wb got st=%0d RegWrite=%b MemToReg=%b RegDst=%b exp 10 1 001 000", Estado[1], RegWrite[1], MemToReg[1], RegDst[1]); else passed++;
      end
      if (c == 11) begin
        total++; if (Estado[1] !== 5'd1) $display("FAIL lw_latency got %0d exp 1", Estado[1]); else passed++;
      end
    end
    // sw on the MEM_WAIT=2 instance: STORE c6..c7, FETCH c8
    start_instr(6'h2B, 6'h00);
    for (int c = 2; c <= 8; c++) begin
      @(negedge Clock);
      total++; if (MemWrite[0] !== (c == 6 || c == 7)) $display("FAIL sw_memwrite_c%0d got %b exp %b", c, MemWrite[0], (c == 6 || c == 7)); else passed++;
      if (c == 8) begin
        total++; if (Estado[0] !== 5'd1) $display("FAIL sw_latency got %0d exp 1", Estado[0]); else passed++;
      end
    end
  endtask

  task automatic test_bad_opcode;
    start_instr(6'h3F, 6'h00);
    repeat (4) @(negedge Clock);
    total++; if (Estado[0] !== 5'd17 || ExcCode[0] !== 2'b00 || EPCWrite[0] !== 1'b1) $display("FAIL badop_exc got st=%0d code=%b EPC=%b exp 17 00 1", Estado[0], ExcCode[0], EPCWrite[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd18 || PCSrc[0] !== 3'b011) $display("FAIL badop_jump got st=%0d PCSrc=%b exp 18 011", Estado[0], PCSrc[0]); else passed++;
  endtask

`ifdef CTRL_MULDIV_EN
  task automatic test_muldiv;
    start_instr(6'h00, 6'h1A);
    repeat (4) @(negedge Clock);
    total++; if (Estado[0] !== 5'd14 || MulDivStart[0] !== 1'b1 || MulDivSel[0] !== 1'b1) $display("FAIL div_start got st=%0d start=%b sel=%b exp 14 1 1", Estado[0], MulDivStart[0], MulDivSel[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd15 || MulDivStart[0] !== 1'b0) $display("FAIL div_run got st=%0d start=%b exp 15 0", Estado[0], MulDivStart[0]); else passed++;
    repeat (63) @(negedge Clock);
    total++; if (Estado[0] !== 5'd15) $display("FAIL div_run_c64 got %0d exp 15", Estado[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd17 || ExcCode[0] !== 2'b11) $display("FAIL div_timeout got st=%0d code=%b exp 17 11", Estado[0], ExcCode[0]); else passed++;
    // Done on the 64th run cycle
    start_instr(6'h00, 6'h1A);
    repeat (68) @(negedge Clock);
    MulDivDone = 1'b1;
    @(negedge Clock);
    MulDivDone = 1'b0;
    total++; if (Estado[0] !== 5'd16 || HiLoWrite[0] !== 1'b1) $display("FAIL div_done_c64 got st=%0d HiLo=%b exp 16 1", Estado[0], HiLoWrite[0]); else passed++;
    @(negedge Clock);
    total++; if (Estado[0] !== 5'd1) $display("FAIL div_wb_return got %0d exp 1", Estado[0]); else passed++;
    // mult, Done on the first run cycle
    start_instr(6'h00, 6'h18);
    repeat (4) @(negedge Clock);
    total++; if (MulDivSel[0] !== 1'b0 || MulDivStart[0] !== 1'b1) $display("FAIL mult_start got sel=%b start=%b exp 0 1", MulDivSel[0], MulDivStart[0]); else passed++;
    @(negedge Clock);
    MulDivDone = 1'b1;
    @(negedge Clock);
    MulDivDone = 1'b0;
    total++; if (Estado[0] !== 5'd16) $display("FAIL mult_done got %0d exp 16", Estado[0]); else passed++;
    // divide by zero
    start_instr(6'h00, 6'h1A);
    DivZero = 1'b1;
    repeat (5) @(negedge Clock);
    total++; if (Estado[0] !== 5'd17 || ExcCode[0] !== 2'b10) $display("FAIL div_zero got st=%0d code=%b exp 17 10", Estado[0], ExcCode[0]); else passed++;
  endtask
`else
  task automatic test_muldiv;
    logic seen;
    seen = 1'b0;
    start_instr(6'h00, 6'h18);
    for (int c = 1; c <= 7; c++) begin
      if (MulDivStart[0] || MulDivSel[0] || HiLoWrite[0]) seen = 1'b1;
      if (c == 5) begin
        total++; if (Estado[0] !== 5'd17 || ExcCode[0] !== 2'b00) $display("FAIL mult_disabled_exc got st=%0d code=%b exp 17 00", Estado[0], ExcCode[0]); else passed++;
      end
      @(negedge Clock);
    end
    total++; if (seen !== 1'b0) $display("FAIL mult_disabled_strobes got %b exp 0", seen); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_rtype;
    test_overflow;
    test_branch;
    test_load_store;
    test_bad_opcode;
    test_muldiv;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
